// File: rtl/uart_pkg.sv
// Shared definitions for the uart_lite AXI-Lite stream bridge.
// Register map, AXI response codes and bridge FSM states.
package uart_pkg;

  localparam logic [31:0] UART_RX_OFS   = 32'h0000_0000;
  localparam logic [31:0] UART_TX_OFS   = 32'h0000_0004;
  localparam logic [31:0] UART_STAT_OFS = 32'h0000_0008;
  localparam logic [31:0] UART_CTRL_OFS = 32'h0000_000C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STAT_AR,
    S_STAT_R,
    S_TX_AW_W,
    S_TX_B,
    S_RX_AR,
    S_RX_R
  } state_t;

endpackage

// File: rtl/uart_axil_stream_bridge_write_pair.sv
// AXI-Lite AW/W launcher: both channels raised together, each
// dropped on its own handshake; done when both have completed.
module axil_write_pair (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  input  logic [3:0]  strb,
  output logic        awvalid,
  output logic [31:0] awaddr,
  input  logic        awready,
  output logic        wvalid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        wready,
  output logic        done
);

  logic busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      awaddr  <= '0;
      wdata   <= '0;
      wstrb   <= '0;
    end else if (start && !busy) begin
      busy    <= 1'b1;
      awvalid <= 1'b1;
      wvalid  <= 1'b1;
      awaddr  <= addr;
      wdata   <= data;
      wstrb   <= strb;
    end else begin
      if (awvalid && awready) awvalid <= 1'b0;
      if (wvalid && wready)   wvalid  <= 1'b0;
      if (done)               busy    <= 1'b0;
    end
  end

  // a channel counts as finished if it already handshook or does so now
  assign done = busy
             && (!awvalid || awready)
             && (!wvalid  || wready);

endmodule

// File: rtl/uart_axil_stream_bridge.sv
// AXI-Lite master feeding uart_lite: pushes TX bytes into the TX
// register and drains RX bytes found by polling the status register.
module uart_axil_stream_bridge
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          POLL_CYCLES  = 16,
  parameter int          TX_FULL_BIT  = 3,
  parameter int          RX_VALID_BIT = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        err_o,
  output logic        cfg_awvalid_o,
  output logic [31:0] cfg_awaddr_o,
  output logic        cfg_wvalid_o,
  output logic [31:0] cfg_wdata_o,
  output logic [3:0]  cfg_wstrb_o,
  output logic        cfg_bready_o,
  output logic        cfg_arvalid_o,
  output logic [31:0] cfg_araddr_o,
  output logic        cfg_rready_o,
  input  logic        cfg_awready_i,
  input  logic        cfg_wready_i,
  input  logic        cfg_bvalid_i,
  input  logic [1:0]  cfg_bresp_i,
  input  logic        cfg_arready_i,
  input  logic        cfg_rvalid_i,
  input  logic [31:0] cfg_rdata_i,
  input  logic [1:0]  cfg_rresp_i
);

  localparam int CW = $clog2(POLL_CYCLES + 1);

  state_t        state, next;
  logic [CW-1:0] poll_cnt;
  logic          tx_full, rx_full;
  logic [7:0]    tx_byte;
  logic          wr_start, wr_done;
  logic          tx_free, rx_load, resp_err;
  logic          unused_rdata;

  assign unused_rdata = ^cfg_rdata_i[31:8];

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= next;
  end

  always_comb begin
    next     = state;
    wr_start = 1'b0;
    tx_free  = 1'b0;
    rx_load  = 1'b0;
    resp_err = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (tx_full || (poll_cnt == '0 && !rx_full))
          next = S_STAT_AR;
      end
      S_STAT_AR: begin
        if (cfg_arready_i) next = S_STAT_R;
      end
      S_STAT_R: begin
        if (cfg_rvalid_i) begin
          next = S_IDLE;
          if (cfg_rresp_i != RESP_OKAY) begin
            resp_err = 1'b1;
          end else if (tx_full && !cfg_rdata_i[TX_FULL_BIT]) begin
            next     = S_TX_AW_W;
            wr_start = 1'b1;
          end else if (cfg_rdata_i[RX_VALID_BIT] && !rx_full) begin
            next = S_RX_AR;
          end
        end
      end
      S_TX_AW_W: begin
        if (wr_done) next = S_TX_B;
      end
      S_TX_B: begin
        if (cfg_bvalid_i) begin
          next     = S_IDLE;
          tx_free  = 1'b1;
          resp_err = (cfg_bresp_i != RESP_OKAY);
        end
      end
      S_RX_AR: begin
        if (cfg_arready_i) next = S_RX_R;
      end
      S_RX_R: begin
        if (cfg_rvalid_i) begin
          next = S_IDLE;
          if (cfg_rresp_i != RESP_OKAY) resp_err = 1'b1;
          else                          rx_load  = 1'b1;
        end
      end
      default: next = S_IDLE;
    endcase
  end

  // read channel driven purely from state, so never from ready
  always_comb begin
    cfg_arvalid_o = (state == S_STAT_AR) || (state == S_RX_AR);
    cfg_rready_o  = (state == S_STAT_R)  || (state == S_RX_R);
    cfg_bready_o  = (state == S_TX_B);
    cfg_araddr_o  = '0;
    if (state == S_STAT_AR) cfg_araddr_o = BASE_ADDR + UART_STAT_OFS;
    if (state == S_RX_AR)   cfg_araddr_o = BASE_ADDR + UART_RX_OFS;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      poll_cnt <= CW'(POLL_CYCLES);
    end else if (state == S_IDLE) begin
      if (next != S_IDLE)     poll_cnt <= CW'(POLL_CYCLES);
      else if (poll_cnt != '0) poll_cnt <= poll_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_full <= 1'b0;
      tx_byte <= '0;
    end else if (tx_free) begin
      tx_full <= 1'b0;
    end else if (tx_valid_i && !tx_full) begin
      tx_full <= 1'b1;
      tx_byte <= tx_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_full   <= 1'b0;
      rx_data_o <= '0;
    end else if (rx_load) begin
      rx_full   <= 1'b1;
      rx_data_o <= cfg_rdata_i[7:0];
    end else if (rx_full && rx_ready_i) begin
      rx_full   <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)         err_o <= 1'b0;
    else if (resp_err) err_o <= 1'b1;
  end

  assign tx_ready_o = !tx_full;
  assign rx_valid_o = rx_full;

  axil_write_pair u_wr (
    .clk     (clk_i),
    .rst     (rst_i),
    .start   (wr_start),
    .addr    (BASE_ADDR + UART_TX_OFS),
    .data    ({24'h0, tx_byte}),
    .strb    (4'b0001),
    .awvalid (cfg_awvalid_o),
    .awaddr  (cfg_awaddr_o),
    .awready (cfg_awready_i),
    .wvalid  (cfg_wvalid_o),
    .wdata   (cfg_wdata_o),
    .wstrb   (cfg_wstrb_o),
    .wready  (cfg_wready_i),
    .done    (wr_done)
  );

endmodule

// File: tb/tb_uart_axil_stream_bridge.sv
// Bench for uart_axil_stream_bridge: AXI-Lite slave model with a
// byte-level reference of the TX/RX streams and protocol monitors.
module tb_uart_axil_stream_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, tx_valid, tx_ready, rx_valid, rx_ready, err;
  logic [7:0]  tx_data, rx_data;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  uart_axil_stream_bridge dut (
    .clk_i(clk), .rst_i(rst),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .err_o(err),
    .cfg_awvalid_o(awvalid), .cfg_awaddr_o(awaddr),
    .cfg_wvalid_o(wvalid), .cfg_wdata_o(wdata), .cfg_wstrb_o(wstrb),
    .cfg_bready_o(bready),
    .cfg_arvalid_o(arvalid), .cfg_araddr_o(araddr), .cfg_rready_o(rready),
    .cfg_awready_i(awready), .cfg_wready_i(wready),
    .cfg_bvalid_i(bvalid), .cfg_bresp_i(bresp),
    .cfg_arready_i(arready), .cfg_rvalid_i(rvalid),
    .cfg_rdata_i(rdata), .cfg_rresp_i(rresp)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // slave knobs and bookkeeping
  int aw_dly = 0, w_dly = 0, ar_dly = 0;
  logic [1:0] bresp_cfg = 2'b00;
  bit b_hold = 0;
  int full_until = 0;
  int n_stat = 0, n_rxrd = 0, n_wr = 0, n_rdone = 0, n_proto = 0;
  byte unsigned rx_q[$], exp_rx[$], got_rx[$], wr_q[$], exp_tx[$];
  int aw_c, w_c, ar_c;
  logic aw_got, w_got;
  logic [7:0] w_byte;

  always @(posedge clk) begin
    byte unsigned b;
    if (rst) begin
      awready <= 0; wready <= 0; arready <= 0;
      bvalid <= 0; bresp <= 0; rvalid <= 0; rdata <= 0; rresp <= 0;
      aw_got <= 0; w_got <= 0; aw_c <= 0; w_c <= 0; ar_c <= 0;
      w_byte <= 0;
    end else begin
      if (awvalid && aw_got) n_proto++;
      if (wvalid && w_got) n_proto++;
      if (awvalid && awready) begin
        awready <= 0; aw_c <= 0; aw_got <= 1;
        if (awaddr != 32'h4) n_proto++;
      end else if (awvalid && !aw_got && !awready) begin
        if (aw_c >= aw_dly) awready <= 1;
        else aw_c <= aw_c + 1;
      end
      if (wvalid && wready) begin
        wready <= 0; w_c <= 0; w_got <= 1; w_byte <= wdata[7:0];
        if (wstrb != 4'h1 || wdata[31:8] != 0) n_proto++;
      end else if (wvalid && !w_got && !wready) begin
        if (w_c >= w_dly) wready <= 1;
        else w_c <= w_c + 1;
      end
      if (bvalid && bready) begin
        bvalid <= 0; aw_got <= 0; w_got <= 0;
        wr_q.push_back(w_byte); n_wr++;
      end else if (aw_got && w_got && !bvalid && !b_hold) begin
        bvalid <= 1; bresp <= bresp_cfg;
      end
      if (rvalid && rready) begin
        rvalid <= 0; n_rdone++;
      end
      if (arvalid && arready) begin
        arready <= 0; ar_c <= 0; rvalid <= 1; rresp <= 2'b00;
        if (araddr == 32'h8) begin
          rdata <= {24'h0,
                    ((n_stat < full_until) ? 8'h08 : 8'h00)
                  | ((rx_q.size() != 0) ? 8'h01 : 8'h00)};
          n_stat++;
        end else if (araddr == 32'h0 && rx_q.size() != 0) begin
          b = rx_q.pop_front();
          rdata <= {24'($urandom), b};
          exp_rx.push_back(b); n_rxrd++;
        end else begin
          rdata <= 0; n_proto++;
        end
      end else if (arvalid && !arready && !rvalid) begin
        if (ar_c >= ar_dly) arready <= 1;
        else ar_c <= ar_c + 1;
      end
      // only one transaction may be outstanding
      if ((arvalid || rvalid) && (awvalid || wvalid || bvalid || aw_got || w_got))
        n_proto++;
    end
  end

  // valid/payload must stay stable until accepted
  logic p_ar = 0, p_aw = 0, p_w = 0;
  logic [31:0] p_araddr, p_awaddr, p_wdata;
  always @(posedge clk) begin
    if (!rst) begin
      if (p_ar && (!arvalid || araddr != p_araddr)) n_proto++;
      if (p_aw && (!awvalid || awaddr != p_awaddr)) n_proto++;
      if (p_w && (!wvalid || wdata != p_wdata)) n_proto++;
    end
    p_ar = arvalid && !arready && !rst; p_araddr = araddr;
    p_aw = awvalid && !awready && !rst; p_awaddr = awaddr;
    p_w  = wvalid && !wready && !rst;   p_wdata = wdata;
  end

  logic rx_man = 0, rnd = 0, rnd_bit = 0;
  always @(negedge clk) rnd_bit <= 1'($urandom);
  assign rx_ready = rnd ? rnd_bit : rx_man;

  always @(posedge clk)
    if (!rst && rx_valid && rx_ready) got_rx.push_back(rx_data);

  task automatic sync_poll();
    int r0 = n_rdone;
    int k = 0;
    while (n_rdone == r0 && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) chk("poll_timeout", 1, 0);
  endtask

  task automatic send_one(input logic [7:0] b, input int polls,
                          output int sd, output logic rdy_bad);
    int s0, w0, k;
    sync_poll();
    s0 = n_stat; w0 = n_wr; full_until = n_stat + polls;
    rdy_bad = !tx_ready;
    tx_data = b; tx_valid = 1;
    @(negedge clk); tx_valid = 0;
    k = 0;
    while (n_wr == w0 && k < 600) begin
      if (tx_ready) rdy_bad = 1;
      @(negedge clk); k++;
    end
    if (k >= 600) chk("write_timeout", 0, 1);
    sd = n_stat - s0;
  endtask

  typedef struct {
    logic [7:0] data;
    int         full_polls;
    logic [1:0] bresp;
    logic       err;
  } vec_t;

  vec_t vt[5];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sd, k, p0, w0, r0;
    logic rb;
    byte unsigned b;

    vt[0] = '{8'h55, 0, 2'b00, 1'b0};
    vt[1] = '{8'hA3, 3, 2'b00, 1'b0};
    vt[2] = '{8'h3C, 1, 2'b10, 1'b1};
    vt[3] = '{8'hC1, 0, 2'b00, 1'b1};
    vt[4] = '{8'h00, 2, 2'b00, 1'b1};

    rst = 1; tx_valid = 0; tx_data = 0;
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rx_valid, err}, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    rst = 0;

    for (int i = 0; i < 5; i++) begin
      bresp_cfg = vt[i].bresp;
      send_one(vt[i].data, vt[i].full_polls, sd, rb);
      chk($sformatf("v%0d_stat_reads", i), sd, vt[i].full_polls + 1);
      chk($sformatf("v%0d_wbyte", i), wr_q[wr_q.size() - 1], vt[i].data);
      chk($sformatf("v%0d_ready_low", i), rb, 0);
      chk($sformatf("v%0d_ready_back", i), tx_ready, 1);
      chk($sformatf("v%0d_err", i), err, vt[i].err);
    end
    bresp_cfg = 2'b00;

    // AW/W skew in both directions
    for (int j = 0; j < 2; j++) begin
      aw_dly = (j == 0) ? 3 : 0;
      w_dly  = (j == 0) ? 0 : 3;
      p0 = n_proto; w0 = n_wr;
      send_one(8'h5A + 8'(j), 0, sd, rb);
      repeat (30) @(negedge clk);
      chk($sformatf("skew%0d_writes", j), n_wr - w0, 1);
      chk($sformatf("skew%0d_byte", j), wr_q[wr_q.size() - 1], 8'h5A + 8'(j));
      chk($sformatf("skew%0d_proto", j), n_proto - p0, 0);
    end
    aw_dly = 0; w_dly = 0;

    // reset while waiting for B
    b_hold = 1;
    sync_poll();
    w0 = n_wr;
    tx_data = 8'hE7; tx_valid = 1;
    @(negedge clk); tx_valid = 0;
    k = 0;
    while (!bready && k < 200) begin @(negedge clk); k++; end
    chk("txb_reached", bready, 1);
    rst = 1;
    @(negedge clk);
    rst = 0; b_hold = 0;
    chk("rstb_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("rstb_tx_ready", tx_ready, 1);
    chk("rstb_err", err, 0);
    repeat (5) @(negedge clk);
    chk("rstb_idle", {arvalid, awvalid, bready}, 0);
    chk("rstb_no_write", n_wr - w0, 0);

    // RX drain with consumer stalled
    rx_q.push_back(8'h9A);
    k = 0;
    while (!rx_valid && k < 200) begin @(negedge clk); k++; end
    chk("rx_valid", rx_valid, 1);
    chk("rx_data", rx_data, 8'h9A);
    r0 = n_rxrd;
    rx_q.push_back(8'h11);
    repeat (60) @(negedge clk);
    chk("rx_held", rx_valid, 1);
    chk("rx_held_data", rx_data, 8'h9A);
    chk("rx_no_extra_read", n_rxrd - r0, 0);
    rx_man = 1; @(negedge clk); rx_man = 0;
    chk("rx_pop", got_rx[got_rx.size() - 1], 8'h9A);
    k = 0;
    while (!rx_valid && k < 200) begin @(negedge clk); k++; end
    chk("rx2_data", rx_data, 8'h11);
    rx_man = 1; @(negedge clk); rx_man = 0;
    chk("rx_err_clean", err, 0);

    // randomized traffic against the byte-stream reference
    rst = 1; @(negedge clk); rst = 0;
    rx_q.delete(); exp_rx.delete(); got_rx.delete();
    wr_q.delete(); exp_tx.delete();
    rnd = 1;
    for (int i = 0; i < 40; i++) begin
      aw_dly = $urandom_range(0, 3);
      w_dly  = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0) rx_q.push_back(8'($urandom));
      if ($urandom_range(0, 3) == 0) full_until = n_stat + $urandom_range(1, 3);
      b = 8'($urandom);
      k = 0;
      while (!tx_ready && k < 800) begin @(negedge clk); k++; end
      if (k >= 800) chk("rand_tx_timeout", 0, 1);
      tx_data = b; tx_valid = 1; exp_tx.push_back(b);
      @(negedge clk); tx_valid = 0;
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end
    k = 0;
    while ((wr_q.size() != exp_tx.size() || rx_q.size() != 0 ||
            got_rx.size() != exp_rx.size()) && k < 5000) begin
      @(negedge clk); k++;
    end
    chk("rand_tx_count", wr_q.size(), exp_tx.size());
    chk("rand_rx_count", got_rx.size(), exp_rx.size());
    for (int i = 0; i < exp_tx.size() && i < wr_q.size(); i++)
      chk($sformatf("rand_tx%0d", i), wr_q[i], exp_tx[i]);
    for (int i = 0; i < exp_rx.size() && i < got_rx.size(); i++)
      chk($sformatf("rand_rx%0d", i), got_rx[i], exp_rx[i]);
    chk("rand_err", err, 0);
    chk("protocol", n_proto, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
